// File: rtl/wb_burst_master.sv
// Wishbone B3 burst master: one command becomes one linear incrementing burst of 1..256 beats.
// Latency: cyc/stb one cycle after command accept; read beats on rdat one cycle after their ack edge.
// Backpressure: write beats stall stb while wdat_valid is low; read data is a valid-only stream with no backpressure.
//
// Ports:
//   wb_clk_i, wb_rst_i        clock, synchronous active-high reset
//   cmd_*                     command: cmd_we (1=write), cmd_adr (byte address, [1:0] ignored), cmd_len (beats-1)
//   wdat_valid/wdat/wdat_ready write data stream, one word consumed per acked write beat
//   rdat_valid/rdat           read data stream, one pulse per acked read beat
//   busy, done, err           cycle in progress; end-of-cycle pulse; abort pulse (coincident with done)
//   wb_*                      Wishbone B3 master interface (registered-feedback burst, linear bte)
//
// Optional feature: define WB_BURST_MASTER_TIMEOUT_EN to abort a burst after TIMEOUT
// consecutive strobed cycles without ack (treated like wb_err_i). Without it the master waits forever.

module wb_burst_master #(
    parameter int dw      = 32,
    parameter int aw      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,

    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_we,
    input  logic [aw-1:0] cmd_adr,
    input  logic [7:0]    cmd_len,

    input  logic          wdat_valid,
    input  logic [dw-1:0] wdat,
    output logic          wdat_ready,

    output logic          rdat_valid,
    output logic [dw-1:0] rdat,

    output logic          busy,
    output logic          done,
    output logic          err,

    output logic [aw-1:0] wb_adr_o,
    output logic [dw-1:0] wb_dat_o,
    output logic [3:0]    wb_sel_o,
    output logic          wb_we_o,
    output logic [1:0]    wb_bte_o,
    output logic [2:0]    wb_cti_o,
    output logic          wb_cyc_o,
    output logic          wb_stb_o,
    input  logic          wb_ack_i,
    input  logic          wb_err_i,
    input  logic [dw-1:0] wb_dat_i
);

    localparam logic [2:0] CTI_INCR = 3'b010;
    localparam logic [2:0] CTI_EOB  = 3'b111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BURST  = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t     state_q;
    state_t     state_d;

    logic [7:0] remaining;
    logic       stb;
    logic       accept;
    logic       beat;
    logic       last_beat;
    logic       abort;
    logic       timeout_hit;

    // Full-word transfers only, linear bursts only.
    assign wb_sel_o   = 4'hF;
    assign wb_bte_o   = 2'b00;
    assign wb_stb_o   = stb;
    assign wb_dat_o   = wdat;
    // Only a real (non-errored) write beat consumes a word from the stream.
    assign wdat_ready = beat && wb_we_o;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        stb       = 1'b0;
        accept    = 1'b0;
        beat      = 1'b0;
        last_beat = 1'b0;
        abort     = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    accept  = 1'b1;
                    state_d = BURST;
                end
            end
            BURST: begin
                // Writes strobe only when a data word is on hand; cyc stays up across gaps.
                stb = wb_we_o ? wdat_valid : 1'b1;
                if (stb && (wb_err_i || timeout_hit)) begin
                    // Error takes priority over a simultaneous ack.
                    abort   = 1'b1;
                    state_d = FINISH;
                end else if (stb && wb_ack_i) begin
                    beat = 1'b1;
                    if (wb_cti_o == CTI_EOB) begin
                        last_beat = 1'b1;
                        state_d   = FINISH;
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wb_cyc_o   <= 1'b0;
            wb_we_o    <= 1'b0;
            wb_adr_o   <= '0;
            wb_cti_o   <= 3'b000;
            remaining  <= 8'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            rdat_valid <= 1'b0;
            rdat       <= '0;
        end else begin
            done       <= 1'b0;
            err        <= 1'b0;
            rdat_valid <= 1'b0;

            if (accept) begin
                wb_we_o   <= cmd_we;
                wb_adr_o  <= cmd_adr & ~aw'(3);
                remaining <= cmd_len;
                wb_cti_o  <= (cmd_len == 8'd0) ? CTI_EOB : CTI_INCR;
                wb_cyc_o  <= 1'b1;
                busy      <= 1'b1;
            end

            if (beat) begin
                // Advance at the ack edge so a registered-feedback slave sees the
                // next address immediately and can ack every cycle.
                wb_adr_o  <= wb_adr_o + aw'(4);
                remaining <= remaining - 8'd1;
                if (remaining == 8'd1) begin
                    wb_cti_o <= CTI_EOB;
                end
                if (!wb_we_o) begin
                    rdat_valid <= 1'b1;
                    rdat       <= wb_dat_i;
                end
            end

            if (last_beat || abort) begin
                wb_cyc_o <= 1'b0;
                busy     <= 1'b0;
                done     <= 1'b1;
                err      <= abort;
            end
        end
    end

`ifdef WB_BURST_MASTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] to_cnt;

    // Counts strobed cycles without ack; any accepted ack restarts the window.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || (state_q != BURST) || (stb && wb_ack_i)) begin
            to_cnt <= '0;
        end else if (stb && !timeout_hit) begin
            to_cnt <= to_cnt + TW'(1);
        end
    end

    // Fires on the TIMEOUT-th stalled cycle; gated with stb in the FSM.
    assign timeout_hit = !wb_ack_i && (to_cnt == TW'(TIMEOUT - 1));
`else
    logic timeout_unused;

    assign timeout_hit    = 1'b0;
    assign timeout_unused = ^TIMEOUT;
`endif

endmodule

// File: tb/tb_wb_burst_master.sv
module tb_wb_burst_master;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [31:0] cmd_adr;
    logic [7:0]  cmd_len;
    logic        wdat_valid;
    logic [31:0] wdat;
    logic        wdat_ready;
    logic        rdat_valid;
    logic [31:0] rdat;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic [1:0]  wb_bte_o;
    logic [2:0]  wb_cti_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_ack_i = 1'b0;
    logic        wb_err_i = 1'b0;
    logic [31:0] wb_dat_i = '0;

    always #5 wb_clk_i = ~wb_clk_i;

    wb_burst_master #(.dw(32), .aw(32), .TIMEOUT(16)) dut (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_i   (wb_rst_i),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_we     (cmd_we),
        .cmd_adr    (cmd_adr),
        .cmd_len    (cmd_len),
        .wdat_valid (wdat_valid),
        .wdat       (wdat),
        .wdat_ready (wdat_ready),
        .rdat_valid (rdat_valid),
        .rdat       (rdat),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .wb_adr_o   (wb_adr_o),
        .wb_dat_o   (wb_dat_o),
        .wb_sel_o   (wb_sel_o),
        .wb_we_o    (wb_we_o),
        .wb_bte_o   (wb_bte_o),
        .wb_cti_o   (wb_cti_o),
        .wb_cyc_o   (wb_cyc_o),
        .wb_stb_o   (wb_stb_o),
        .wb_ack_i   (wb_ack_i),
        .wb_err_i   (wb_err_i),
        .wb_dat_i   (wb_dat_i)
    );

    // ---------------- RAM slave model (registered-feedback B3 bursts) ----------------
    logic [31:0] mem [256];
    logic        pl_we = 1'b0;
    logic [7:0]  pl_idx = '0;
    logic [31:0] pl_dat = '0;
    logic        err_mode = 1'b0;
    logic        noack_mode = 1'b0;
    int          s_beats = 0;

    always @(posedge wb_clk_i) begin : slave
        logic [31:0] nxt;
        if (pl_we) mem[pl_idx] <= pl_dat;
        if (wb_cyc_o && wb_stb_o && wb_ack_i && wb_we_o) mem[wb_adr_o[9:2]] <= wb_dat_o;
        if (!wb_cyc_o) s_beats <= 0;
        else if (wb_ack_i && wb_stb_o) s_beats <= s_beats + 1;
        nxt = (wb_ack_i && wb_stb_o) ? wb_adr_o + 32'd4 : wb_adr_o;
        wb_ack_i <= 1'b0;
        wb_err_i <= 1'b0;
        if (wb_cyc_o && wb_stb_o && !noack_mode && !wb_err_i &&
            !(wb_ack_i && wb_cti_o == 3'b111)) begin
            if (err_mode && (s_beats + (wb_ack_i ? 1 : 0)) == 2) begin
                wb_err_i <= 1'b1;
            end else begin
                wb_ack_i <= 1'b1;
                wb_dat_i <= mem[nxt[9:2]];
            end
        end
    end

    // ---------------- checking helpers ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic issue(input logic we, input logic [31:0] adr, input logic [7:0] len);
        int n;
        n = 0;
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_len   = len;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 20) begin
            tick();
            n++;
        end
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic preload(input logic [7:0] idx, input logic [31:0] dat);
        pl_we  = 1'b1;
        pl_idx = idx;
        pl_dat = dat;
        tick();
        pl_we  = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    logic [31:0] wd [8];

    initial begin
        int idx, stall, stb_low, k, n, acks, cyc_hi, pulses;
        logic xfer, done_seen, err_seen;

        wb_rst_i   = 1'b1;
        cmd_valid  = 1'b0;
        cmd_we     = 1'b0;
        cmd_adr    = '0;
        cmd_len    = '0;
        wdat_valid = 1'b0;
        wdat       = '0;
        for (int i = 0; i < 8; i++) wd[i] = 32'hC0DE_0000 + 32'(i * 17);

        // Reset state
        tick();
        tick();
        chk("rst_cyc",  {31'd0, wb_cyc_o}, 32'd0);
        chk("rst_stb",  {31'd0, wb_stb_o}, 32'd0);
        chk("rst_we",   {31'd0, wb_we_o}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err",  {31'd0, err}, 32'd0);
        chk("rst_rval", {31'd0, rdat_valid}, 32'd0);
        chk("rst_adr",  wb_adr_o, 32'd0);
        chk("rst_cti",  {29'd0, wb_cti_o}, 32'd0);
        chk("rst_bte",  {30'd0, wb_bte_o}, 32'd0);
        chk("rst_sel",  {28'd0, wb_sel_o}, 32'hF);
        wb_rst_i = 1'b0;
        tick();
        chk("idle_rdy", {31'd0, cmd_ready}, 32'd1);

        preload(8'h10, 32'hA0);
        preload(8'h11, 32'hA1);
        preload(8'h12, 32'hA2);
        preload(8'h13, 32'hA3);

        // Read burst 0x40, 4 beats (address bits [1:0] must be ignored)
        issue(1'b0, 32'h0000_0043, 8'd3);
        chk("rd_c1_cyc",  {31'd0, wb_cyc_o}, 32'd1);
        chk("rd_c1_stb",  {31'd0, wb_stb_o}, 32'd1);
        chk("rd_c1_busy", {31'd0, busy}, 32'd1);
        chk("rd_c1_we",   {31'd0, wb_we_o}, 32'd0);
        chk("rd_c1_adr",  wb_adr_o, 32'h40);
        chk("rd_c1_cti",  {29'd0, wb_cti_o}, 32'd2);
        tick();
        chk("rd_c2_adr",  wb_adr_o, 32'h40);
        tick();
        chk("rd_c3_adr",  wb_adr_o, 32'h44);
        chk("rd_c3_cti",  {29'd0, wb_cti_o}, 32'd2);
        chk("rd_c3_rv",   {31'd0, rdat_valid}, 32'd1);
        chk("rd_c3_rdat", rdat, 32'hA0);
        tick();
        chk("rd_c4_adr",  wb_adr_o, 32'h48);
        chk("rd_c4_cti",  {29'd0, wb_cti_o}, 32'd2);
        chk("rd_c4_rdat", rdat, 32'hA1);
        tick();
        chk("rd_c5_adr",  wb_adr_o, 32'h4C);
        chk("rd_c5_cti",  {29'd0, wb_cti_o}, 32'd7);
        chk("rd_c5_rv",   {31'd0, rdat_valid}, 32'd1);
        chk("rd_c5_rdat", rdat, 32'hA2);
        chk("rd_c5_cyc",  {31'd0, wb_cyc_o}, 32'd1);
        tick();
        chk("rd_c6_cyc",  {31'd0, wb_cyc_o}, 32'd0);
        chk("rd_c6_done", {31'd0, done}, 32'd1);
        chk("rd_c6_err",  {31'd0, err}, 32'd0);
        chk("rd_c6_busy", {31'd0, busy}, 32'd0);
        chk("rd_c6_rdat", rdat, 32'hA3);
        tick();
        chk("rd_c7_done", {31'd0, done}, 32'd0);
        chk("rd_c7_rv",   {31'd0, rdat_valid}, 32'd0);

        // Write burst 0x10, 8 beats, 2-cycle data gap after beat 3
        issue(1'b1, 32'h10, 8'd7);
        idx = 0; stall = 0; stb_low = 0; done_seen = 1'b0;
        wdat_valid = 1'b1;
        wdat = wd[0];
        for (int c = 0; c < 60 && !done_seen; c++) begin
            #2;
            if (wb_cyc_o && !wb_stb_o) stb_low++;
            xfer = wdat_ready;
            tick();
            if (done) done_seen = 1'b1;
            if (xfer) idx++;
            if (xfer && idx == 4) stall = 2;
            if (stall > 0) begin
                wdat_valid = 1'b0;
                stall--;
            end else begin
                wdat_valid = (idx < 8);
                wdat = (idx < 8) ? wd[idx] : 32'd0;
            end
        end
        wdat_valid = 1'b0;
        chk("wr_done",    {31'd0, done_seen}, 32'd1);
        chk("wr_beats",   idx, 32'd8);
        chk("wr_stb_gap", stb_low, 32'd2);

        // Readback of the written words
        issue(1'b0, 32'h10, 8'd7);
        k = 0; done_seen = 1'b0;
        for (int c = 0; c < 40 && !done_seen; c++) begin
            if (rdat_valid) begin
                chk($sformatf("rb%0d", k), rdat, wd[(k < 8) ? k : 0]);
                k++;
            end
            if (done) done_seen = 1'b1;
            if (!done_seen) tick();
        end
        chk("rb_count", k, 32'd8);
        tick();

        // Single beat read
        issue(1'b0, 32'h44, 8'd0);
        chk("sb_cti", {29'd0, wb_cti_o}, 32'd7);
        acks = 0; cyc_hi = 0;
        for (int c = 0; c < 20 && (wb_cyc_o || c == 0); c++) begin
            if (wb_cyc_o) cyc_hi++;
            if (wb_ack_i && wb_stb_o) acks++;
            tick();
        end
        chk("sb_cyc_len", cyc_hi, 32'd2);
        chk("sb_acks",    acks, 32'd1);
        chk("sb_rdat",    rdat, 32'hA1);
        chk("sb_done",    {31'd0, done}, 32'd1);
        tick();

        // Error on beat 2 of a 4-beat read
        err_mode = 1'b1;
        issue(1'b0, 32'h40, 8'd3);
        pulses = 0; err_seen = 1'b0; done_seen = 1'b0;
        for (int c = 0; c < 20 && !done_seen; c++) begin
            if (rdat_valid) pulses++;
            if (done) done_seen = 1'b1;
            if (err_seen) begin
                chk("er_cyc_low", {31'd0, wb_cyc_o}, 32'd0);
                chk("er_err",     {31'd0, err}, 32'd1);
                chk("er_done",    {31'd0, done}, 32'd1);
                err_seen = 1'b0;
            end
            if (wb_err_i && wb_stb_o) err_seen = 1'b1;
            if (!done_seen) tick();
        end
        chk("er_pulses",   pulses, 32'd2);
        chk("er_finished", {31'd0, done_seen}, 32'd1);
        err_mode = 1'b0;
        tick();

        // Reset in the middle of an 8-beat write
        issue(1'b1, 32'h80, 8'd7);
        idx = 0;
        wdat_valid = 1'b1;
        for (int c = 0; c < 40 && idx < 5; c++) begin
            wdat = 32'h5000 + 32'(idx);
            #2;
            xfer = wdat_ready;
            tick();
            if (xfer) idx++;
        end
        wb_rst_i = 1'b1;
        tick();
        wb_rst_i = 1'b0;
        wdat_valid = 1'b0;
        chk("mr_cyc",  {31'd0, wb_cyc_o}, 32'd0);
        chk("mr_stb",  {31'd0, wb_stb_o}, 32'd0);
        chk("mr_done", {31'd0, done}, 32'd0);
        chk("mr_rdy",  {31'd0, cmd_ready}, 32'd1);
        issue(1'b0, 32'h48, 8'd0);
        chk("mr_new_busy", {31'd0, busy}, 32'd1);
        chk("mr_new_cyc",  {31'd0, wb_cyc_o}, 32'd1);
        chk("mr_new_adr",  wb_adr_o, 32'h48);
        done_seen = 1'b0;
        for (int c = 0; c < 20 && !done_seen; c++) begin
            if (done) done_seen = 1'b1;
            else tick();
        end
        chk("mr_new_done", {31'd0, done_seen}, 32'd1);
        chk("mr_new_rdat", rdat, 32'hA2);
        tick();

        // Slave never acks
        noack_mode = 1'b1;
        issue(1'b0, 32'h40, 8'd3);
`ifdef WB_BURST_MASTER_TIMEOUT_EN
        n = 0;
        while (!err && n < 100) begin
            n++;
            tick();
        end
        chk("to_stall_cycles", n, 32'd16);
        chk("to_done",         {31'd0, done}, 32'd1);
        chk("to_cyc",          {31'd0, wb_cyc_o}, 32'd0);
`else
        n = 0;
        for (int c = 0; c < 1000; c++) begin
            if (wb_cyc_o) n++;
            tick();
        end
        chk("noto_cyc_held", n, 32'd1000);
        chk("noto_no_err",   {31'd0, err}, 32'd0);
        wb_rst_i = 1'b1;
        tick();
        wb_rst_i = 1'b0;
        chk("noto_rst_cyc",  {31'd0, wb_cyc_o}, 32'd0);
`endif
        noack_mode = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
